// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: stage entry layout, select encoding
// and the availability stages for ALU and load results.
package fwd_pkg;

  localparam int unsigned FWD_DST_W   = 8;
  localparam int unsigned FWD_AVAIL_W = 8;

  typedef logic [FWD_DST_W-1:0]   fwd_dst_t;
  typedef logic [FWD_AVAIL_W-1:0] fwd_avail_t;

  typedef struct packed {
    logic       v;
    fwd_dst_t   dst;
    fwd_avail_t avail;
  } fwd_entry_t;

  localparam int unsigned FWD_RF = 0;

  localparam fwd_avail_t AVAIL_ALU = fwd_avail_t'(1);

  function automatic fwd_avail_t AVAIL_LD(input int load_lat);
    return fwd_avail_t'(1 + load_lat);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search of the scoreboard for one operand; the youngest matching stage
// wins and its readiness decides between a forward select and a hazard.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW        = 4,
  parameter int FWD_DEPTH = 2,
  parameter int SW        = $clog2(FWD_DEPTH + 1)
) (
  input  fwd_entry_t [FWD_DEPTH-1:0] entries,
  input  logic [AW-1:0]              addr,
  input  logic                       re,
  input  logic                       offset,
  output logic [SW-1:0]              sel,
  output logic                       hazard
);

  logic found;

  // offset adds one stage of slack for operands consumed later than EX
  always_comb begin
    sel    = SW'(FWD_RF);
    hazard = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (!found && entries[k].v && (entries[k].dst == fwd_dst_t'(addr)) &&
          (addr != '0) && re) begin
        found = 1'b1;
        if (fwd_avail_t'(k + 1) + fwd_avail_t'(offset) >= entries[k].avail) begin
          sel = SW'(k + 1);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Registered shift-scoreboard of in-flight register writes producing operand and
// store-data forward selects plus a bubble request for the decode instruction.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int AW        = 4,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  localparam int SW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    p0_addr,
  input  logic [AW-1:0]    p1_addr,
  input  logic             re0,
  input  logic             re1,
  input  logic             is_store,
  input  logic [AW-1:0]    dst_addr,
  input  logic             we,
  input  logic             mem_re,
  input  logic             issue_valid,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [SW-1:0]    src0_fwd,
  output logic [SW-1:0]    src1_fwd,
  output logic [SW-1:0]    st_fwd,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  fwd_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic                       haz0, haz1, haz_st;

  fwd_match #(.AW(AW), .FWD_DEPTH(FWD_DEPTH), .SW(SW)) u_src0 (
    .entries(sb_q), .addr(p0_addr), .re(re0), .offset(1'b0),
    .sel(src0_fwd), .hazard(haz0)
  );

  fwd_match #(.AW(AW), .FWD_DEPTH(FWD_DEPTH), .SW(SW)) u_src1 (
    .entries(sb_q), .addr(p1_addr), .re(re1 && !is_store), .offset(1'b0),
    .sel(src1_fwd), .hazard(haz1)
  );

  // store data is consumed in MEM, one stage after an ALU operand
  fwd_match #(.AW(AW), .FWD_DEPTH(FWD_DEPTH), .SW(SW)) u_st (
    .entries(sb_q), .addr(p1_addr), .re(re1 && is_store), .offset(1'b1),
    .sel(st_fwd), .hazard(haz_st)
  );

  assign bubble    = issue_valid && !flush && (haz0 || haz1 || haz_st);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (!mem_stall) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sb_d[k] = sb_q[k-1];
      end
      sb_d[0].v     = issue_valid && !flush && !bubble && we && (dst_addr != '0);
      sb_d[0].dst   = fwd_dst_t'(dst_addr);
      sb_d[0].avail = mem_re ? AVAIL_LD(LOAD_LAT) : AVAIL_ALU;
      if (bubble && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
